planificador_necesidades: RTL
=============================

Name: planificador_necesidades

Overview:
- Scheduler and arbiter for the pet's need datapath (Energia, Medicina, Descanso, Animo).
- Arbitrates user or sensor action requests so exactly one action is served at a time. Each granted action is held for a fixed window, followed by a cooldown.
- Independently schedules per-need decay ticks that tell the level datapath when to drop a need LED level.
- Test mode compresses time so the whole sequence can be exercised quickly on the board.

Parameters:
- CLK_FREQ, 50000000, clock cycles per real second.
- TEST_CYCLES, 50000, cycles per "second" while Bot_Test=1.
- ACTION_SEC, 5, seconds a granted action is held.
- COOLDOWN_SEC, 2, seconds after an action during which no new grant is issued.
- DECAY_E, 20, seconds between Energia decay ticks.
- DECAY_M, 40, seconds between Medicina decay ticks.
- DECAY_D, 30, seconds between Descanso decay ticks.
- DECAY_A, 15, seconds between Animo decay ticks.

Ports:
- clk  in  1  system clock.
- Bot_Reset  in  1  asynchronous, active-low reset.
- Bot_Test  in  1  level; 1 = accelerated time base (TEST_CYCLES per second).
- en  in  1  pet alive; 0 freezes all timers and blocks new grants.
- req  in  4  level requests, already synchronised and debounced: bit0 Energia, bit1 Medicina, bit2 Descanso, bit3 Animo.
- grant  out  4  one-hot, held for the whole action window.
- busy  out  1  high in GRANT or COOLDOWN.
- senal_5seg  out  1  one-cycle pulse when an action window completes normally.
- tick_decay  out  4  one-cycle pulse per need when its decay period elapses; bit order as req.

Behaviour:
- Reset (Bot_Reset=0, asynchronous):
  - grant=0, busy=0, senal_5seg=0, tick_decay=0.
  - FSM=IDLE; prescaler, second counters and rr_ptr cleared; rr_ptr=0 (Energia has highest priority first).
- Time base:
  - Prescaler counts to P-1, where P = Bot_Test ? TEST_CYCLES : CLK_FREQ, then emits internal sec_tick and wraps to 0.
  - Any edge on Bot_Test clears the prescaler.
  - Prescaler holds while en=0.
- FSM IDLE -> GRANT:
  - In IDLE, when en=1 and req!=0, a round-robin pick is made starting at rr_ptr.
  - grant goes one-hot on the next clock; busy=1 on the same edge.
  - Prescaler and action counter are cleared on entry.
  - rr_ptr is set to (granted index + 1) mod 4.
- GRANT:
  - Action counter increments on sec_tick.
  - When it reaches ACTION_SEC, pulse senal_5seg for one cycle, drop grant and go to COOLDOWN. This happens exactly ACTION_SEC*P cycles after grant rose.
  - If the granted req bit drops during GRANT, abort: grant=0, no senal_5seg, go to COOLDOWN next cycle.
  - Other req bits changing during GRANT are ignored.
- COOLDOWN:
  - Prescaler and counter are cleared on entry.
  - After COOLDOWN_SEC seconds go to IDLE; busy=0 in the same cycle as the transition.
  - Requests still held are arbitrated in IDLE one cycle later.
- Multiple simultaneous requests: round-robin only, no starvation. Across continuous requests, each bit is granted at most once per 4 grants.
- Decay scheduling:
  - Four independent second counters. Counter i increments on sec_tick; at its DECAY period it pulses tick_decay[i] and wraps to 0.
  - While grant[i]=1, counter i is held at 0 and tick_decay[i] is suppressed (the need is being served).
  - Several tick_decay bits may pulse in the same cycle.
  - Counters do not clear on prescaler restarts; ±1 s jitter on decay timing is accepted.
- en=0:
  - Any GRANT is aborted to COOLDOWN.
  - Timers freeze; tick_decay=0.
  - On en=1 the FSM resumes from where it was.
- Reset mid-window: everything returns to reset values immediately; no senal_5seg pulse.
- Widths: counters sized $clog2 of their maximum; no saturation required beyond wrap.

Decomposition:
- Shared package `pet_pkg`:
  - need index constants NEED_E=0, NEED_M=1, NEED_D=2, NEED_A=3;
  - FSM state encoding IDLE/GRANT/COOLDOWN;
  - default second periods.
- One natural sub-module: `prescaler_seg` (clk, Bot_Reset, Bot_Test, en, clear -> sec_tick), reusable by the level datapath.
- Round-robin pick is inline combinational logic.

Test Plan (CLK_FREQ=10, TEST_CYCLES=2, ACTION_SEC=5, COOLDOWN_SEC=2, DECAY_A=3, others 100):
- Reset, en=1, req=0001 held -> grant=0001 one cycle later, busy=1; senal_5seg pulses 50 cycles after grant rose; grant=0; busy falls 20 cycles later.
- req=1111 held for 4 windows -> grant order 0001, 0010, 0100, 1000; no bit granted twice.
- req=0010 granted, then drops after 12 cycles -> grant=0 next cycle, no senal_5seg, busy=1 for the 20-cycle cooldown.
- Idle with no requests -> tick_decay[3] pulses every 30 cycles; with req=1000 granted, no tick_decay[3] during the window, first pulse 30 cycles after the grant ends.
- Bot_Test=1 -> action window is 10 cycles and cooldown 4 cycles; toggling Bot_Test mid-window restarts the prescaler count.
- Bot_Reset low at cycle 25 of a window -> grant, busy and counters are 0 immediately; no senal_5seg; after release, rr_ptr=0.

Source files
------------

// File: rtl/pet_pkg.sv
// rtl/pet_pkg.sv - shared need indices, FSM encoding and default periods for the pet datapath
package pet_pkg;

    localparam int NEED_E  = 0;
    localparam int NEED_M  = 1;
    localparam int NEED_D  = 2;
    localparam int NEED_A  = 3;
    localparam int N_NEEDS = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam int DEF_CLK_FREQ    = 50000000;
    localparam int DEF_TEST_CYCLES = 50000;
    localparam int DEF_ACTION_SEC  = 5;
    localparam int DEF_COOLDOWN_SEC = 2;
    localparam int DEF_DECAY_E     = 20;
    localparam int DEF_DECAY_M     = 40;
    localparam int DEF_DECAY_D     = 30;
    localparam int DEF_DECAY_A     = 15;

    // Bits needed to count 0..max_val-1, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/prescaler_seg.sv
// rtl/prescaler_seg.sv - one-second tick generator with normal and accelerated time bases
module prescaler_seg
    import pet_pkg::*;
#(
    parameter int CLK_FREQ    = DEF_CLK_FREQ,
    parameter int TEST_CYCLES = DEF_TEST_CYCLES
) (
    input  logic clk,
    input  logic Bot_Reset,
    input  logic Bot_Test,
    input  logic en,
    input  logic clear,
    output logic sec_tick
);

    localparam int PMAX = (CLK_FREQ > TEST_CYCLES) ? CLK_FREQ : TEST_CYCLES;
    localparam int PW   = cnt_width(PMAX);

    logic [PW-1:0] cnt;
    logic [PW-1:0] last;
    logic          test_q;
    logic          test_edge;

    assign last      = Bot_Test ? PW'(TEST_CYCLES - 1) : PW'(CLK_FREQ - 1);
    assign test_edge = Bot_Test ^ test_q;
    // A mode switch restarts the second, so no tick may escape on the switch cycle.
    assign sec_tick  = en && !test_edge && (cnt == last);

    always_ff @(posedge clk or negedge Bot_Reset) begin
        if (!Bot_Reset) begin
            cnt    <= '0;
            test_q <= 1'b0;
        end else begin
            test_q <= Bot_Test;
            if (clear || test_edge) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= (cnt == last) ? '0 : cnt + PW'(1);
            end
        end
    end

endmodule

// File: rtl/planificador_necesidades.sv
// rtl/planificador_necesidades.sv - round-robin action arbiter with timed windows and per-need decay ticks
module planificador_necesidades
    import pet_pkg::*;
#(
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int TEST_CYCLES  = DEF_TEST_CYCLES,
    parameter int ACTION_SEC   = DEF_ACTION_SEC,
    parameter int COOLDOWN_SEC = DEF_COOLDOWN_SEC,
    parameter int DECAY_E      = DEF_DECAY_E,
    parameter int DECAY_M      = DEF_DECAY_M,
    parameter int DECAY_D      = DEF_DECAY_D,
    parameter int DECAY_A      = DEF_DECAY_A
) (
    input  logic       clk,
    input  logic       Bot_Reset,
    input  logic       Bot_Test,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       busy,
    output logic       senal_5seg,
    output logic [3:0] tick_decay
);

    localparam int SMAX = (ACTION_SEC > COOLDOWN_SEC) ? ACTION_SEC : COOLDOWN_SEC;
    localparam int CW   = cnt_width(SMAX);

    state_t       state;
    logic [CW-1:0] sec_cnt;
    logic [1:0]   rr_ptr;
    logic [1:0]   gnt_idx;
    logic         sec_tick;
    logic         clear;
    logic         pick_valid;
    logic [1:0]   pick_idx;
    logic [1:0]   cand;
    logic         abort;
    logic         win_done;
    logic         cd_done;

    prescaler_seg #(
        .CLK_FREQ   (CLK_FREQ),
        .TEST_CYCLES(TEST_CYCLES)
    ) u_prescaler (
        .clk      (clk),
        .Bot_Reset(Bot_Reset),
        .Bot_Test (Bot_Test),
        .en       (en),
        .clear    (clear),
        .sec_tick (sec_tick)
    );

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = rr_ptr;
        cand       = rr_ptr;
        for (int k = N_NEEDS - 1; k >= 0; k--) begin
            cand = rr_ptr + 2'(k);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign abort    = !en || !req[gnt_idx];
    assign win_done = sec_tick && (sec_cnt == CW'(ACTION_SEC - 1));
    assign cd_done  = sec_tick && (sec_cnt == CW'(COOLDOWN_SEC - 1));

    always_comb begin
        clear = 1'b0;
        case (state)
            IDLE:    clear = en && pick_valid;
            GRANT:   clear = abort || win_done;
            default: clear = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge Bot_Reset) begin
        if (!Bot_Reset) begin
            state      <= IDLE;
            sec_cnt    <= '0;
            rr_ptr     <= 2'd0;
            gnt_idx    <= 2'd0;
            grant      <= 4'b0;
            busy       <= 1'b0;
            senal_5seg <= 1'b0;
        end else begin
            senal_5seg <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && pick_valid) begin
                        state   <= GRANT;
                        grant   <= 4'(1) << pick_idx;
                        busy    <= 1'b1;
                        gnt_idx <= pick_idx;
                        rr_ptr  <= pick_idx + 2'd1;
                        sec_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (abort) begin
                        grant   <= 4'b0;
                        state   <= COOLDOWN;
                        sec_cnt <= '0;
                    end else if (win_done) begin
                        grant      <= 4'b0;
                        senal_5seg <= 1'b1;
                        state      <= COOLDOWN;
                        sec_cnt    <= '0;
                    end else if (sec_tick) begin
                        sec_cnt <= sec_cnt + CW'(1);
                    end
                end
                COOLDOWN: begin
                    if (cd_done) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        sec_cnt <= '0;
                    end else if (sec_tick) begin
                        sec_cnt <= sec_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 4'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_NEEDS; i++) begin : g_decay
        localparam int PER = (i == NEED_E) ? DECAY_E :
                             (i == NEED_M) ? DECAY_M :
                             (i == NEED_D) ? DECAY_D : DECAY_A;
        localparam int DW  = cnt_width(PER);

        logic [DW-1:0] dcnt;
        logic          dtick;

        // A need being served does not decay; its period restarts once the grant ends.
        always_ff @(posedge clk or negedge Bot_Reset) begin
            if (!Bot_Reset) begin
                dcnt  <= '0;
                dtick <= 1'b0;
            end else begin
                dtick <= 1'b0;
                if (grant[i]) begin
                    dcnt <= '0;
                end else if (sec_tick) begin
                    if (dcnt == DW'(PER - 1)) begin
                        dcnt  <= '0;
                        dtick <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
            end
        end

        assign tick_decay[i] = dtick;
    end

endmodule
